instr_commit_multi: RTL and testbench

INSTR_COMMIT_MULTI -- requirements
Module: instr_commit_multi

---
 rtl/instr_commit_multi.sv | 180 ++++++++++++++++++
 tb/tb_instr_commit_multi.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_commit_multi.sv
// Multi-slot commit stage: retires ROB packets, drains their stores in slot order,
// writes back results and raises exception/flush with a post-flush hold window.
package instr_commit_multi_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } data_memreq_t;
endpackage

module instr_commit_multi
  import instr_commit_multi_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rob_empty,
  input  logic [WIDTH-1:0]        rob_valid,
  input  logic [WIDTH-1:0]        rob_busy,
  input  logic [WIDTH-1:0]        rob_store,
  input  logic [WIDTH-1:0]        rob_except,
  input  logic [WIDTH-1:0][31:0]  rob_pc,
  input  logic [WIDTH-1:0][31:0]  rob_value,
  input  logic [WIDTH-1:0][4:0]   rob_dest,
  input  data_memreq_t [WIDTH-1:0] rob_memreq,
  output logic                    rob_ack,
  output logic [WIDTH-1:0]        reg_we,
  output logic [WIDTH-1:0][4:0]   reg_waddr,
  output logic [WIDTH-1:0][31:0]  reg_wdata,
  output data_memreq_t            lsu_store_memreq,
  output logic                    lsu_store_push,
  input  logic                    lsu_store_full,
  output logic                    except_valid,
  output logic [31:0]             except_pc,
  output logic                    commit_flush,
  output logic [31:0]             commit_flush_pc,
  output logic [31:0]             commit_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]             r_state;
  logic [3:0]             r_hold_cnt;
  logic [WIDTH-1:0]       r_pushed;
  logic [WIDTH-1:0]       r_reg_we;
  logic [WIDTH-1:0][4:0]  r_reg_waddr;
  logic [WIDTH-1:0][31:0] r_reg_wdata;
  logic                   r_except_valid;
  logic                   r_commit_flush;
  logic [31:0]            r_except_pc;
  logic [31:0]            r_flush_pc;
  logic [31:0]            r_commit_count;

  logic                   w_found;
  logic [WIDTH-1:0]       w_below;
  logic [WIDTH-1:0]       w_retire;
  logic [31:0]            w_cut_pc;
  logic [2:0]             w_nret;
  logic                   w_busy;
  logic                   w_ready;
  logic [WIDTH-1:0]       w_elig;
  logic [WIDTH-1:0]       w_pend;
  logic [WIDTH-1:0]       w_sel_oh;
  logic                   w_has_pend;
  logic                   w_last;
  logic                   w_push;
  logic                   w_ack;
  data_memreq_t           w_memreq;

  // Cut point: the first valid excepting slot; everything below it retires.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    w_found  = 1'b0;
    w_below  = '0;
    w_cut_pc = '0;
    w_nret   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!w_found) begin
        if (rob_valid[i] && rob_except[i]) begin
          w_found  = 1'b1;
          w_cut_pc = rob_pc[i];
        end else begin
          w_below[i] = 1'b1;
        end
      end
    end
    w_retire = rob_valid & w_below;
    for (int i = 0; i < WIDTH; i++) begin
      w_nret = w_nret + {2'b00, w_retire[i]};
    end
  end

  always_comb begin
    w_busy     = |(rob_valid & rob_busy);
    w_ready    = rst && !rob_empty && (r_state == ST_RUN) && !w_busy;
    w_elig     = rob_valid & rob_store & w_below;
    w_pend     = w_elig & ~r_pushed;
    w_has_pend = |w_pend;
    w_sel_oh   = '0;
    w_memreq   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_memreq    = rob_memreq[i];
      end
    end
    // The packet retires together with its final store push.
    w_last = ((w_pend & ~w_sel_oh) == '0);
    w_push = w_ready && w_has_pend && !lsu_store_full;
    w_ack  = w_ready && (!w_has_pend || (w_push && w_last));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_hold_cnt     <= '0;
      r_except_valid <= 1'b0;
      r_commit_flush <= 1'b0;
      r_except_pc    <= '0;
      r_flush_pc     <= '0;
    end else begin
      // NOTE: registers update with <= so every block samples the same pre-edge values.
      r_except_valid <= 1'b0;
      r_commit_flush <= 1'b0;
      if (r_state == ST_RUN) begin
        if (w_ack && w_found) begin
          r_except_valid <= 1'b1;
          r_commit_flush <= 1'b1;
          r_except_pc    <= w_cut_pc;
          r_flush_pc     <= w_cut_pc;
          r_hold_cnt     <= 4'(FLUSH_HOLD);
          r_state        <= ST_HOLD;
        end
      end else if (r_hold_cnt == 4'd0) begin
        r_state <= ST_RUN;
      end else begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pushed       <= '0;
      r_reg_we       <= '0;
      r_reg_waddr    <= '0;
      r_reg_wdata    <= '0;
      r_commit_count <= '0;
    end else begin
      if (w_ack) begin
        r_pushed <= '0;
      end else if (w_push) begin
        r_pushed <= r_pushed | w_sel_oh;
      end
      r_reg_we <= w_ack ? w_retire : '0;
      if (w_ack) begin
        r_reg_waddr    <= rob_dest;
        r_reg_wdata    <= rob_value;
        r_commit_count <= r_commit_count + 32'(w_nret);
      end
    end
  end

  assign rob_ack          = w_ack;
  assign lsu_store_push   = w_push;
  assign lsu_store_memreq = w_memreq;
  assign reg_we           = r_reg_we;
  assign reg_waddr        = r_reg_waddr;
  assign reg_wdata        = r_reg_wdata;
  assign except_valid     = r_except_valid;
  assign except_pc        = r_except_pc;
  assign commit_flush     = r_commit_flush;
  assign commit_flush_pc  = r_flush_pc;
  assign commit_count     = r_commit_count;

endmodule

// File: tb/tb_instr_commit_multi.sv
// Bench for instr_commit_multi: a WIDTH=2 and a WIDTH=4 instance share one stimulus set;
// a table, directed sequences and a random run are checked against a packet-level model.
module tb_instr_commit_multi;
  import instr_commit_multi_pkg::*;

  logic clk, rst, rob_empty, lsu_full;
  logic [3:0] valid, busy, store, exc;
  logic [3:0][31:0] pc, value;
  logic [3:0][4:0] dest;
  data_memreq_t [3:0] memreq;

  logic a_ack, a_push, a_exv, a_fl;
  logic [1:0] a_we;
  logic [1:0][4:0] a_waddr;
  logic [1:0][31:0] a_wdata;
  logic [31:0] a_expc, a_flpc, a_cnt;
  data_memreq_t a_mreq;

  logic b_ack, b_push, b_exv, b_fl;
  logic [3:0] b_we;
  logic [3:0][4:0] b_waddr;
  logic [3:0][31:0] b_wdata;
  logic [31:0] b_expc, b_flpc, b_cnt;
  data_memreq_t b_mreq;

  instr_commit_multi #(.WIDTH(2), .FLUSH_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .rob_empty(rob_empty),
    .rob_valid(valid[1:0]), .rob_busy(busy[1:0]), .rob_store(store[1:0]), .rob_except(exc[1:0]),
    .rob_pc(pc[1:0]), .rob_value(value[1:0]), .rob_dest(dest[1:0]), .rob_memreq(memreq[1:0]),
    .rob_ack(a_ack), .reg_we(a_we), .reg_waddr(a_waddr), .reg_wdata(a_wdata),
    .lsu_store_memreq(a_mreq), .lsu_store_push(a_push), .lsu_store_full(lsu_full),
    .except_valid(a_exv), .except_pc(a_expc), .commit_flush(a_fl), .commit_flush_pc(a_flpc),
    .commit_count(a_cnt));

  instr_commit_multi #(.WIDTH(4), .FLUSH_HOLD(3)) dut4 (
    .clk(clk), .rst(rst), .rob_empty(rob_empty),
    .rob_valid(valid), .rob_busy(busy), .rob_store(store), .rob_except(exc),
    .rob_pc(pc), .rob_value(value), .rob_dest(dest), .rob_memreq(memreq),
    .rob_ack(b_ack), .reg_we(b_we), .reg_waddr(b_waddr), .reg_wdata(b_wdata),
    .lsu_store_memreq(b_mreq), .lsu_store_push(b_push), .lsu_store_full(lsu_full),
    .except_valid(b_exv), .except_pc(b_expc), .commit_flush(b_fl), .commit_flush_pc(b_flpc),
    .commit_count(b_cnt));

  // Outputs of the instance currently under test, widened to 4 slots.
  logic sel;
  logic o_ack, o_push, o_exv, o_fl;
  logic [3:0] o_we;
  logic [3:0][4:0] o_waddr;
  logic [3:0][31:0] o_wdata;
  logic [31:0] o_expc, o_flpc, o_cnt;
  data_memreq_t o_mreq;

  always_comb begin
    o_ack   = sel ? b_ack   : a_ack;
    o_push  = sel ? b_push  : a_push;
    o_mreq  = sel ? b_mreq  : a_mreq;
    o_we    = sel ? b_we    : {2'b00, a_we};
    o_waddr = sel ? b_waddr : {10'b0, a_waddr};
    o_wdata = sel ? b_wdata : {64'b0, a_wdata};
    o_exv   = sel ? b_exv   : a_exv;
    o_expc  = sel ? b_expc  : a_expc;
    o_fl    = sel ? b_fl    : a_fl;
    o_flpc  = sel ? b_flpc  : a_flpc;
    o_cnt   = sel ? b_cnt   : a_cnt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- packet-level reference model ----------------
  int m_n, m_fh, m_block;
  int q[$];
  bit m_ack, m_push;
  logic [3:0] exp_we;
  logic [3:0][4:0] exp_waddr;
  logic [3:0][31:0] exp_wdata;
  logic exp_exv;
  logic [31:0] exp_pc, exp_cnt;
  int pkt_id = 0;

  function automatic int cut();
    for (int i = 0; i < m_n; i++) if (valid[i] && exc[i]) return i;
    return m_n;
  endfunction

  task automatic build_queue();
    int k;
    k = cut();
    q.delete();
    for (int i = 0; i < k; i++) if (valid[i] && store[i]) q.push_back(i);
  endtask

  task automatic model_reset();
    exp_we = '0; exp_exv = 1'b0; exp_pc = '0; exp_cnt = '0; m_block = 0;
    build_queue();
  endtask

  task automatic idle();
    rob_empty = 1'b1; valid = '0; busy = '0; store = '0; exc = '0;
  endtask

  task automatic set_packet(input logic [3:0] v, input logic [3:0] b, input logic [3:0] s,
                            input logic [3:0] e);
    valid = v; busy = b; store = s; exc = e; rob_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc[i]          = 32'h0040_0000 + 32'(pkt_id * 16 + i * 4);
      value[i]       = $urandom;
      dest[i]        = 5'($urandom);
      memreq[i].addr = 32'h8000_0000 + 32'(pkt_id * 64 + i * 8);
      memreq[i].data = $urandom;
      memreq[i].be   = 4'($urandom);
    end
    pkt_id++;
    build_queue();
  endtask

  // One cycle: sample just after the falling edge, compare, then advance the model.
  task automatic step();
    int k;
    bit busy_any;
    #1;
    if (!rst) model_reset();
    busy_any = 1'b0;
    for (int i = 0; i < m_n; i++) if (valid[i] && busy[i]) busy_any = 1'b1;
    m_push = rst && !rob_empty && m_block == 0 && !busy_any && q.size() > 0 && !lsu_full;
    m_ack  = rst && !rob_empty && m_block == 0 && !busy_any &&
             (q.size() == 0 || (m_push && q.size() == 1));
    check("ack", o_ack, m_ack);
    check("push", o_push, m_push);
    if (m_push) check("store_memreq", o_mreq, memreq[q[0]]);
    check("reg_we", o_we, exp_we);
    for (int i = 0; i < 4; i++) begin
      if (exp_we[i]) begin
        check("reg_waddr", o_waddr[i], exp_waddr[i]);
        check("reg_wdata", o_wdata[i], exp_wdata[i]);
      end
    end
    check("except_valid", o_exv, exp_exv);
    check("commit_flush", o_fl, exp_exv);
    if (exp_exv) begin
      check("except_pc", o_expc, exp_pc);
      check("flush_pc", o_flpc, exp_pc);
    end
    check("commit_count", o_cnt, exp_cnt);
    if (m_push) void'(q.pop_front());
    exp_we = '0;
    exp_exv = 1'b0;
    if (m_block > 0) m_block--;
    if (m_ack) begin
      k = cut();
      for (int i = 0; i < k; i++) begin
        exp_we[i] = valid[i];
        exp_waddr[i] = dest[i];
        exp_wdata[i] = value[i];
        if (valid[i]) exp_cnt = exp_cnt + 32'd1;
      end
      if (k < m_n) begin
        exp_exv = 1'b1;
        exp_pc = pc[k];
        m_block = 1 + m_fh;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); lsu_full = 1'b0; rst = 1'b0;
    step();
    @(negedge clk); rst = 1'b1;
    step();
  endtask

  typedef struct {
    logic [1:0] v, b, s, e;
    logic emp, full, ack, push;
    logic [1:0] we;
    logic fl;
  } vec_t;
  vec_t tbl [14];

  initial begin
    int np;
    logic [31:0] c0;
    bit need_new, seen_ack;

    tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    tbl[2]  = '{2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0};
    tbl[5]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[7]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[8]  = '{2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[11] = '{2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0};
    tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[13] = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1};

    sel = 1'b0; m_n = 2; m_fh = 2;
    rst = 1'b0; lsu_full = 1'b0;
    set_packet(4'b0011, 4'b0000, 4'b0001, 4'b0000);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ack_a", a_ack, 1'b0);
    check("rst_push_a", a_push, 1'b0);
    check("rst_we_a", a_we, 2'b00);
    check("rst_waddr_a", a_waddr, 10'd0);
    check("rst_wdata_a", a_wdata, 64'd0);
    check("rst_exv_a", a_exv, 1'b0);
    check("rst_expc_a", a_expc, 32'd0);
    check("rst_flush_a", a_fl, 1'b0);
    check("rst_flpc_a", a_flpc, 32'd0);
    check("rst_cnt_a", a_cnt, 32'd0);
    check("rst_ack_b", b_ack, 1'b0);
    check("rst_push_b", b_push, 1'b0);
    check("rst_cnt_b", b_cnt, 32'd0);
    @(negedge clk); rst = 1'b1; idle();

    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      valid = {2'b00, tbl[t].v}; busy = {2'b00, tbl[t].b};
      store = {2'b00, tbl[t].s}; exc = {2'b00, tbl[t].e};
      rob_empty = tbl[t].emp; lsu_full = tbl[t].full;
      #1;
      check($sformatf("tbl%0d_ack", t), o_ack, tbl[t].ack);
      check($sformatf("tbl%0d_push", t), o_push, tbl[t].push);
      @(negedge clk); idle(); lsu_full = 1'b0;
      #1;
      check($sformatf("tbl%0d_we", t), o_we, {2'b00, tbl[t].we});
      check($sformatf("tbl%0d_flush", t), o_fl, tbl[t].fl);
      repeat (4) @(negedge clk);
    end

    // Two-slot ALU packet retires at once.
    do_reset();
    @(negedge clk); set_packet(4'b0011, 4'b0000, 4'b0000, 4'b0000); step();
    check("alu2_ack", o_ack, 1'b1);
    @(negedge clk); idle(); step();
    check("alu2_we", o_we, 4'b0011);
    check("alu2_cnt", o_cnt, 32'd2);

    // Slot-1 exception: partial writeback, one-cycle flush, then two blocked cycles.
    @(negedge clk); set_packet(4'b0011, 4'b0000, 4'b0000, 4'b0010);
    pc[1] = 32'hBFC0_0100; step();
    check("exc1_ack", o_ack, 1'b1);
    @(negedge clk); set_packet(4'b0011, 4'b0000, 4'b0000, 4'b0000); step();
    check("exc1_we", o_we, 4'b0001);
    check("exc1_exv", o_exv, 1'b1);
    check("exc1_flush", o_fl, 1'b1);
    check("exc1_flpc", o_flpc, 32'hBFC0_0100);
    check("exc1_expc", o_expc, 32'hBFC0_0100);
    check("exc1_pulse_noack", o_ack, 1'b0);
    repeat (2) begin
      @(negedge clk); step();
      check("exc1_hold_noack", o_ack, 1'b0);
      check("exc1_flush_once", o_fl, 1'b0);
    end
    @(negedge clk); step();
    check("exc1_resume_ack", o_ack, 1'b1);
    @(negedge clk); idle(); step();

    // Slot-0 exception suppresses the slot-1 store and all writeback.
    c0 = exp_cnt;
    @(negedge clk); set_packet(4'b0011, 4'b0000, 4'b0010, 4'b0001); step();
    check("exc0_ack", o_ack, 1'b1);
    np = int'(o_push);
    @(negedge clk); idle(); step();
    np += int'(o_push);
    check("exc0_we", o_we, 4'b0000);
    check("exc0_cnt", o_cnt, c0);
    check("exc0_pushes", np, 0);
    repeat (3) begin @(negedge clk); step(); end

    // Counter wrap.
    @(negedge clk); dut2.r_commit_count = 32'hFFFF_FFFF; exp_cnt = 32'hFFFF_FFFF; step();
    @(negedge clk); set_packet(4'b0011, 4'b0000, 4'b0000, 4'b0000); step();
    @(negedge clk); idle(); step();
    check("wrap_cnt", o_cnt, 32'd1);

    // Four-slot instance: store drain with back-pressure.
    sel = 1'b1; m_n = 4; m_fh = 3;
    do_reset();
    @(negedge clk); set_packet(4'b1111, 4'b0000, 4'b0101, 4'b0000); step();
    check("drain_push0", o_push, 1'b1);
    check("drain_req0", o_mreq, memreq[0]);
    check("drain_ack0", o_ack, 1'b0);
    np = int'(o_push);
    repeat (2) begin
      @(negedge clk); lsu_full = 1'b1; step();
      np += int'(o_push);
      check("drain_full_ack", o_ack, 1'b0);
    end
    @(negedge clk); lsu_full = 1'b0; step();
    np += int'(o_push);
    check("drain_req2", o_mreq, memreq[2]);
    check("drain_ack2", o_ack, 1'b1);
    @(negedge clk); idle(); step();
    np += int'(o_push);
    check("drain_pushes", np, 2);
    check("drain_we", o_we, 4'b1111);

    // Reset in the middle of a drain discards progress.
    @(negedge clk); set_packet(4'b1111, 4'b0000, 4'b1111, 4'b0000); step();
    @(negedge clk); step();
    @(negedge clk); rst = 1'b0; step();
    check("mrst_cnt", o_cnt, 32'd0);
    check("mrst_push", o_push, 1'b0);
    check("mrst_ack", o_ack, 1'b0);
    check("mrst_we", o_we, 4'b0000);
    @(negedge clk); rst = 1'b1; step();
    check("mrst_repush", o_push, 1'b1);
    check("mrst_req0", o_mreq, memreq[0]);
    np = int'(o_push);
    seen_ack = 1'b0;
    for (int c = 0; c < 10 && !seen_ack; c++) begin
      @(negedge clk); step();
      np += int'(o_push);
      seen_ack = o_ack;
    end
    check("mrst_ack_seen", seen_ack, 1'b1);
    check("mrst_pushes", np, 4);
    @(negedge clk); idle(); step();

    // Random packets with random back-pressure and busy bits.
    need_new = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (need_new) begin
        if ($urandom_range(0, 3) == 0) idle();
        else begin
          set_packet(4'($urandom), 4'b0000, 4'($urandom),
                     4'($urandom) & 4'($urandom) & 4'($urandom));
          need_new = 1'b0;
        end
      end
      busy = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      lsu_full = ($urandom_range(0, 2) == 0);
      step();
      if (m_ack) need_new = 1'b1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
